// File: rtl/cmem_wr_arbiter_pkg.sv
// Shared constants for the CNN result-memory write path: default widths,
// memory select codes and a select-validity helper.
package cnn_pkg;

  localparam int DATAW_DEF = 20;
  localparam int ADDRW_DEF = 12;

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0K0 = 3'b001;
  localparam logic [2:0] CSEL_L0K1 = 3'b010;
  localparam logic [2:0] CSEL_L1K0 = 3'b011;
  localparam logic [2:0] CSEL_L1K1 = 3'b100;
  localparam logic [2:0] CSEL_L2   = 3'b101;

  // Only 001..101 address a real memory; 000 and 11x are dropped.
  function automatic logic csel_valid(input logic [2:0] sel);
    return (sel != CSEL_NONE) && (sel <= CSEL_L2);
  endfunction

endpackage

// File: rtl/cmem_wr_arbiter_if.sv
// Requester-side handshake plus the shared memory write port; the bench
// drives through master, the arbiter sits on slave.
interface cmem_wr_arbiter_if
  import cnn_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DATAW = DATAW_DEF,
  parameter int ADDRW = ADDRW_DEF
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [3*NREQ-1:0]     req_sel;
  logic [ADDRW*NREQ-1:0] req_addr;
  logic [DATAW*NREQ-1:0] req_data;
  logic                  hold;

  logic                  cwr;
  logic [2:0]            csel;
  logic [ADDRW-1:0]      caddr_wr;
  logic [DATAW-1:0]      cdata_wr;
  logic [2:0]            grant_id;
  logic                  idle;
  logic                  sel_err;

  modport master (
    output req_valid, req_sel, req_addr, req_data, hold,
    input  req_ready, cwr, csel, caddr_wr, cdata_wr, grant_id, idle, sel_err
  );

  modport slave (
    input  req_valid, req_sel, req_addr, req_data, hold,
    output req_ready, cwr, csel, caddr_wr, cdata_wr, grant_id, idle, sel_err
  );

endinterface

// File: rtl/cmem_wr_arbiter_wr_req_fifo.sv
// Two-entry per-requester write FIFO; push is ignored when full, pop when empty.
// Simultaneous push and pop keeps the count and the order.
module wr_req_fifo #(
  parameter int W = 35
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign do_push = push_i && (count_q != 2'd2);
  assign do_pop  = pop_i && (count_q != 2'd0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ~wr_ptr_q;
    if (do_pop)  rd_ptr_d = ~rd_ptr_q;
    if (do_push && !do_pop)      count_d = count_q + 2'd1;
    else if (!do_push && do_pop) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides what is live.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/cmem_wr_arbiter.sv
// Round-robin arbiter sharing the result-memory write port among NREQ
// requester FIFOs; one registered write per cycle, 2-edge push-to-port latency.
module cmem_wr_arbiter
  import cnn_pkg::*;
#(
  parameter int DATAW = DATAW_DEF,
  parameter int ADDRW = ADDRW_DEF,
  parameter int NREQ  = 4
) (
  input logic               clk,
  input logic               reset,
  cmem_wr_arbiter_if.slave  bus
);

  localparam int EW   = 3 + ADDRW + DATAW;
  localparam int NMAX = 8;

  logic [EW-1:0]   head [NMAX];
  logic [NMAX-1:0] nonempty;
  logic [NREQ-1:0] ready;
  logic [NREQ-1:0] bad_push;

  logic            gnt_vld;
  logic [2:0]      gnt_idx;
  logic [3:0]      cand;
  logic [2:0]      rr_q, rr_d;

  logic [EW-1:0]    win;
  logic [2:0]       win_sel;
  logic             wr_ok;

  logic             cwr_q, cwr_d;
  logic [2:0]       csel_q, csel_d;
  logic [ADDRW-1:0] caddr_q, caddr_d;
  logic [DATAW-1:0] cdata_q, cdata_d;
  logic [2:0]       gid_q, gid_d;
  logic             sel_err_q, sel_err_d;

  for (genvar i = 0; i < NMAX; i++) begin : g_req
    if (i < NREQ) begin : g_on
      logic       push_s, pop_s;
      logic [1:0] cnt_s;

      assign push_s = bus.req_valid[i] && ready[i];
      assign pop_s  = gnt_vld && (gnt_idx == 3'(i));

      wr_req_fifo #(.W(EW)) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .din_i   ({bus.req_sel[3*i +: 3],
                   bus.req_addr[ADDRW*i +: ADDRW],
                   bus.req_data[DATAW*i +: DATAW]}),
        .head_o  (head[i]),
        .count_o (cnt_s)
      );

      assign nonempty[i] = (cnt_s != 2'd0);
      assign ready[i]    = (cnt_s != 2'd2);
      assign bad_push[i] = push_s && !csel_valid(bus.req_sel[3*i +: 3]);
    end else begin : g_off
      assign nonempty[i] = 1'b0;
      assign head[i]     = '0;
    end
  end

  // First non-empty FIFO at or after rr_q, wrapping modulo NREQ.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_q} + 4'(k);
      if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
      if (!bus.hold && !gnt_vld && nonempty[cand[2:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[2:0];
      end
    end
  end

  assign win     = head[gnt_idx];
  assign win_sel = win[EW-1 -: 3];
  assign wr_ok   = gnt_vld && csel_valid(win_sel);

  always_comb begin
    rr_d      = rr_q;
    cwr_d     = wr_ok;
    csel_d    = 3'b000;
    gid_d     = 3'd0;
    caddr_d   = caddr_q;
    cdata_d   = cdata_q;
    sel_err_d = sel_err_q || (|bad_push);
    if (gnt_vld) begin
      rr_d = (gnt_idx == 3'(NREQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
    end
    // Invalid selects still consume the grant but leave the port quiet.
    if (wr_ok) begin
      csel_d  = win_sel;
      gid_d   = gnt_idx;
      caddr_d = win[DATAW +: ADDRW];
      cdata_d = win[DATAW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q      <= 3'd0;
      cwr_q     <= 1'b0;
      csel_q    <= 3'b000;
      gid_q     <= 3'd0;
      caddr_q   <= '0;
      cdata_q   <= '0;
      sel_err_q <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      cwr_q     <= cwr_d;
      csel_q    <= csel_d;
      gid_q     <= gid_d;
      caddr_q   <= caddr_d;
      cdata_q   <= cdata_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.cwr       = cwr_q;
  assign bus.csel      = csel_q;
  assign bus.caddr_wr  = caddr_q;
  assign bus.cdata_wr  = cdata_q;
  assign bus.grant_id  = gid_q;
  assign bus.sel_err   = sel_err_q;
  assign bus.idle      = (nonempty == '0) && !cwr_q;

endmodule

// File: tb/tb_cmem_wr_arbiter.sv
// Directed-vector bench for cmem_wr_arbiter with hand-computed expectations.
module tb_cmem_wr_arbiter;
  import cnn_pkg::*;

  localparam int NREQ  = 4;
  localparam int DATAW = 20;
  localparam int ADDRW = 12;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cmem_wr_arbiter_if #(.NREQ(NREQ), .DATAW(DATAW), .ADDRW(ADDRW)) bus ();

  cmem_wr_arbiter #(.DATAW(DATAW), .ADDRW(ADDRW), .NREQ(NREQ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] sel,
                         input logic [ADDRW-1:0] addr, input logic [DATAW-1:0] data);
    bus.req_sel[3*i +: 3]         = sel;
    bus.req_addr[ADDRW*i +: ADDRW] = addr;
    bus.req_data[DATAW*i +: DATAW] = data;
    bus.req_valid[i]              = 1'b1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_sel   = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.hold      = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       f0, f2, started;
    logic [2:0] exp_id;
    int         nx0, nx2, e0, e2, nwr, gaps, ex;

    // Reset state and a single write
    do_reset();
    chk("rst_cwr",   32'(bus.cwr), 0);
    chk("rst_csel",  32'(bus.csel), 0);
    chk("rst_addr",  32'(bus.caddr_wr), 0);
    chk("rst_data",  32'(bus.cdata_wr), 0);
    chk("rst_gid",   32'(bus.grant_id), 0);
    chk("rst_idle",  32'(bus.idle), 1);
    chk("rst_serr",  32'(bus.sel_err), 0);
    chk("rst_ready", 32'(bus.req_ready), 'hF);

    set_req(0, CSEL_L0K0, 12'h041, 20'h0ABCD);
    tick();
    bus.req_valid = '0;
    chk("sw_lat_cwr", 32'(bus.cwr), 0);
    tick();
    chk("sw_cwr",  32'(bus.cwr), 1);
    chk("sw_csel", 32'(bus.csel), 1);
    chk("sw_addr", 32'(bus.caddr_wr), 'h041);
    chk("sw_data", 32'(bus.cdata_wr), 'h0ABCD);
    chk("sw_gid",  32'(bus.grant_id), 0);
    chk("sw_busy", 32'(bus.idle), 0);
    tick();
    chk("sw_done_cwr",  32'(bus.cwr), 0);
    chk("sw_done_csel", 32'(bus.csel), 0);
    chk("sw_done_idle", 32'(bus.idle), 1);
    chk("sw_hold_addr", 32'(bus.caddr_wr), 'h041);

    // Round-robin from rr_ptr=0, then from rr_ptr=2
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, CSEL_L0K1, 12'(16 + i), 20'(256 + i));
    tick();
    bus.req_valid = '0;
    for (int j = 0; j < NREQ; j++) begin
      tick();
      chk("rr0_cwr",  32'(bus.cwr), 1);
      chk("rr0_gid",  32'(bus.grant_id), 32'(j));
      chk("rr0_addr", 32'(bus.caddr_wr), 32'(16 + j));
    end
    tick();
    chk("rr0_end_cwr", 32'(bus.cwr), 0);

    set_req(1, CSEL_L1K0, 12'h020, 20'h00020);
    tick();
    bus.req_valid = '0;
    tick();
    chk("rr_pre_gid", 32'(bus.grant_id), 1);
    for (int i = 0; i < NREQ; i++) set_req(i, CSEL_L1K1, 12'(48 + i), 20'(512 + i));
    tick();
    bus.req_valid = '0;
    for (int j = 0; j < NREQ; j++) begin
      ex = (2 + j) % NREQ;
      tick();
      chk("rr2_cwr",  32'(bus.cwr), 1);
      chk("rr2_gid",  32'(bus.grant_id), 32'(ex));
      chk("rr2_addr", 32'(bus.caddr_wr), 32'(48 + ex));
    end

    // Backpressure under hold
    do_reset();
    bus.hold = 1'b1;
    set_req(1, CSEL_L0K0, 12'h050, 20'h00050);
    tick();
    chk("bp_rdy1", 32'(bus.req_ready[1]), 1);
    set_req(1, CSEL_L0K0, 12'h051, 20'h00051);
    tick();
    chk("bp_rdy2", 32'(bus.req_ready[1]), 0);
    set_req(1, CSEL_L0K0, 12'h052, 20'h00052);
    tick();
    tick();
    chk("bp_full_rdy", 32'(bus.req_ready[1]), 0);
    chk("bp_hold_cwr", 32'(bus.cwr), 0);
    chk("bp_hold_idle", 32'(bus.idle), 0);
    bus.hold = 1'b0;
    tick();
    chk("bp_w0_cwr",  32'(bus.cwr), 1);
    chk("bp_w0_addr", 32'(bus.caddr_wr), 'h050);
    chk("bp_w0_rdy",  32'(bus.req_ready[1]), 1);
    tick();
    bus.req_valid = '0;
    chk("bp_w1_addr", 32'(bus.caddr_wr), 'h051);
    chk("bp_w1_gid",  32'(bus.grant_id), 1);
    tick();
    chk("bp_w2_cwr",  32'(bus.cwr), 1);
    chk("bp_w2_addr", 32'(bus.caddr_wr), 'h052);
    tick();
    chk("bp_end_cwr",  32'(bus.cwr), 0);
    chk("bp_end_idle", 32'(bus.idle), 1);

    // Sustained stream from requesters 0 and 2
    do_reset();
    nx0 = 0; nx2 = 0; e0 = 0; e2 = 0; nwr = 0; gaps = 0;
    started = 1'b0;
    exp_id  = 3'd0;
    set_req(0, CSEL_L0K0, 12'h100, 20'd0);
    set_req(2, CSEL_L1K0, 12'h200, 20'd0);
    for (int c = 0; c < 400; c++) begin
      f0 = bus.req_valid[0] && bus.req_ready[0];
      f2 = bus.req_valid[2] && bus.req_ready[2];
      tick();
      if (f0) nx0++;
      if (f2) nx2++;
      if (bus.cwr) begin
        chk("ss_gid", 32'(bus.grant_id), 32'(exp_id));
        chk("ss_addr", 32'(bus.caddr_wr), (exp_id == 3'd0) ? 32'(256 + e0) : 32'(512 + e2));
        if (exp_id == 3'd0) e0++;
        else e2++;
        exp_id  = (exp_id == 3'd0) ? 3'd2 : 3'd0;
        nwr++;
        started = 1'b1;
      end else if (started && nwr < 128) begin
        gaps++;
      end
      if (nx0 < 64) set_req(0, CSEL_L0K0, 12'(256 + nx0), 20'(nx0));
      else bus.req_valid[0] = 1'b0;
      if (nx2 < 64) set_req(2, CSEL_L1K0, 12'(512 + nx2), 20'(nx2));
      else bus.req_valid[2] = 1'b0;
      if (nwr >= 128) break;
    end
    chk("ss_nwr",  32'(nwr), 128);
    chk("ss_gaps", 32'(gaps), 0);
    chk("ss_n0",   32'(e0), 64);
    chk("ss_n2",   32'(e2), 64);
    tick();
    chk("ss_end_cwr", 32'(bus.cwr), 0);

    // Invalid selects are dropped and flag sel_err
    do_reset();
    set_req(3, CSEL_NONE, 12'h333, 20'h03333);
    tick();
    chk("inv_serr_set", 32'(bus.sel_err), 1);
    set_req(3, 3'b110, 12'h334, 20'h03334);
    tick();
    chk("inv_000_cwr", 32'(bus.cwr), 0);
    chk("inv_000_gid", 32'(bus.grant_id), 0);
    set_req(3, CSEL_L2, 12'h055, 20'h05555);
    tick();
    bus.req_valid = '0;
    chk("inv_110_cwr", 32'(bus.cwr), 0);
    tick();
    chk("inv_ok_cwr",  32'(bus.cwr), 1);
    chk("inv_ok_csel", 32'(bus.csel), 5);
    chk("inv_ok_addr", 32'(bus.caddr_wr), 'h055);
    chk("inv_ok_data", 32'(bus.cdata_wr), 'h05555);
    chk("inv_ok_gid",  32'(bus.grant_id), 3);
    tick();
    chk("inv_sticky", 32'(bus.sel_err), 1);

    // Reset with entries queued behind hold
    bus.hold = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, CSEL_L0K0, 12'(96 + i), 20'(96 + i));
    tick();
    bus.req_valid = '0;
    chk("mr_queued_idle", 32'(bus.idle), 0);
    reset    = 1'b1;
    bus.hold = 1'b0;
    tick();
    reset = 1'b0;
    chk("mr_cwr",   32'(bus.cwr), 0);
    chk("mr_idle",  32'(bus.idle), 1);
    chk("mr_serr",  32'(bus.sel_err), 0);
    chk("mr_ready", 32'(bus.req_ready), 'hF);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("mr_no_write", 32'(bus.cwr), 0);
    end
    chk("mr_end_idle", 32'(bus.idle), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cmem_wr_arbiter.md
Name: cmem_wr_arbiter

Overview:
- Shares the single result-memory write port (csel/caddr_wr/cdata_wr/cwr) among NREQ independent write requesters: conv kernel 0, conv kernel 1, maxpool 0 and maxpool 1.
- Flattening writes are issued by the requesters via their own csel.
- Each requester owns a 2-entry request FIFO with a valid/ready handshake.
- A round-robin arbiter drains one FIFO entry per cycle onto a registered write port. Requesters no longer need hand-built csel timing chains.

Parameters:
- DATAW, 20, data width of one memory word
- ADDRW, 12, memory address width
- NREQ, 4, number of requesters (2..8)

Ports:
- clk  input  1  clock, all state updates on posedge
- reset  input  1  synchronous, active-high reset
- req_valid  input  NREQ  bit i: requester i presents a write
- req_ready  output  NREQ  bit i: FIFO i can accept (registered, not full)
- req_sel  input  3*NREQ  slice i: target memory select for requester i (001..101)
- req_addr  input  ADDRW*NREQ  slice i: write address
- req_data  input  DATAW*NREQ  slice i: write data
- hold  input  1  stall: no grant issued while high
- cwr  output  1  write strobe to memory
- csel  output  3  memory select; 000 when cwr low
- caddr_wr  output  ADDRW  write address
- cdata_wr  output  DATAW  write data
- grant_id  output  3  index of requester whose write is on the port (0 when idle)
- idle  output  1  all FIFOs empty and cwr low
- sel_err  output  1  sticky: a request with req_sel of 000 or 11x was accepted

Behaviour:
- Reset (reset high at posedge):
  - FIFOs flush, RR pointer goes to 0.
  - cwr, csel, caddr_wr, cdata_wr, grant_id and sel_err all go to 0; idle goes to 1.
  - req_ready goes to all-ones on the following cycle.
  - Reset mid-burst discards queued entries with no partial write.
- Handshake:
  - Transfer on requester i occurs at a posedge where req_valid[i] and req_ready[i] are both 1.
  - req_ready[i] = (fifo_count[i] != 2), taken from registers only. A full FIFO stays not-ready in a cycle where it is also popped; there is no same-cycle push-through.
- FIFO: 2 entries of {sel, addr, data}. Push and pop in the same cycle leave the count unchanged and preserve order.
- Arbitration:
  - Combinational each cycle over the set of non-empty FIFOs, only when hold is 0.
  - Search starts at index rr_ptr and wraps modulo NREQ. The first non-empty FIFO wins.
  - On a grant to index g: pop FIFO g and set rr_ptr to (g+1) mod NREQ.
  - No grant leaves rr_ptr unchanged.
- Output register, loaded at each posedge:
  - On grant: cwr=1, csel=entry.sel, caddr_wr=entry.addr, cdata_wr=entry.data, grant_id=g.
  - Otherwise: cwr=0, csel=000, grant_id=0. caddr_wr and cdata_wr hold their previous values.
- Latency: a transfer at posedge k with an empty system and hold low puts the write on the port in the cycle after posedge k+1 (2 edges). Throughput is 1 write/cycle sustained.
- Invalid select: a req_sel of 000 or 11x is still accepted, popped and dropped (cwr stays 0 that slot), and sel_err sets until reset.
- hold:
  - hold=1 blocks grants and leaves FIFO contents and rr_ptr intact.
  - The output register clears cwr at the next edge.
  - Pushes continue until the FIFOs are full.
- idle = (all fifo_count == 0) && !cwr, combinational from registers.
- Ordering: per-requester order is preserved; there is no ordering guarantee across requesters.
- Starvation: worst-case wait for any non-empty FIFO with hold low is NREQ-1 grants.

Decomposition:
- Package cnn_pkg holds:
  - DATAW and ADDRW defaults.
  - CSEL constants: CSEL_NONE=000, CSEL_L0K0=001, CSEL_L0K1=010, CSEL_L1K0=011, CSEL_L1K1=100, CSEL_L2=101.
  - A validity function for csel.
- Sub-module wr_req_fifo: 2-entry FIFO with push, pop, count, head outputs. It is instantiated NREQ times via generate.
- The arbiter and output register live in the top module.

Test Plan:
- Single write: reset 2 cycles; req 0 pushes {sel=001, addr=0x041, data=0x0ABCD} at edge k. Required: cwr=1, csel=001, caddr_wr=0x041, cdata_wr=0x0ABCD, grant_id=0 after edge k+1, and cwr=0 at k+2 with idle=1.
- Round-robin: all 4 requesters push one entry at the same edge, with addresses 0x10..0x13. Required: port order 0,1,2,3 on consecutive cycles. Repeat with rr_ptr=2 and require order 2,3,0,1.
- Backpressure: hold=1, requester 1 pushes 3 times. Required: req_ready[1]=0 after the 2nd transfer and the 3rd waits. Release hold: writes appear in push order and req_ready[1] returns to 1 one cycle after the first pop.
- Sustained stream: requesters 0 and 2 keep valid high for 64 writes each. Required: 128 consecutive cwr cycles, strict alternation 0/2, no lost or duplicated addresses.
- Invalid select: requester 3 pushes sel=000. Required: no cwr pulse for that slot and sel_err=1 sticky. A following sel=101 write appears normally.
- Reset mid-operation: 4 entries queued, then reset pulsed for 1 cycle. Required: cwr=0, idle=1, no queued write ever appears, sel_err=0.
